fft_host_loader: RTL
====================

# fft_host_loader

Host-side loader bridging a narrow configuration bus to the sample RAM ports of the iterative FFT core. It generalises the fixed two-port, 32-bit staging register file to NCH channels of IWL-bit samples assembled from BW-bit bus words. It adds a write-enable-qualified register map, registered readback, and a commit state machine that honours the core's RAM block signal. Optional address auto-increment and a start pulse to launch the transform are also provided. The block sits between the test/host interface and `top_fft_iter`.

## Interface
- IWL, 32, sample width per channel (complex re/im packed); must be a multiple of BW
- BW, 16, host bus data width; WPS = IWL/BW words per sample
- AWL, 7, RAM address width
- NCH, 2, number of RAM write channels (channel 0 = A, 1 = B, ...)
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-low
- i_EN  in  1  global enable; low freezes all state
- i_WE  in  1  host register write strobe
- i_ADDR  in  8  host register index
- i_DATA  in  BW  host write data
- o_RDATA  out  BW  registered readback of register at i_ADDR
- i_RAM_BLOCK  in  1  core busy; RAM writes must not be issued while high
- o_RAM_DATA  out  NCH*IWL  channel samples, channel c at [c*IWL +: IWL]
- o_RAM_ADDR  out  NCH*AWL  channel addresses, channel c at [c*AWL +: AWL]
- o_RAM_Wr  out  1  one-cycle RAM write pulse
- o_START  out  1  one-cycle FFT start pulse
- o_BUSY  out  1  commit in progress; host writes ignored

## Operation
- Register map, S = WPS+1: index c*S+k (k<WPS) = channel c data word k, k=0 most significant slice; index c*S+WPS = channel c address (low AWL bits kept); index NCH*S = CTRL; other indices write-ignored, read 0.
- CTRL bits: [0] COMMIT (self-clearing, reads 0), [1] AUTOINC (sticky), [2] START (self-clearing, reads 0).
- Host write accepted only when i_EN=1, i_WE=1, FSM in IDLE; otherwise dropped silently.
- FSM states: IDLE, WAIT, WRITE.
  - IDLE: accepted COMMIT -> WRITE if i_RAM_BLOCK=0, else WAIT.
  - WAIT: -> WRITE when i_RAM_BLOCK=0.
  - WRITE: o_RAM_Wr=1 for this cycle only; -> IDLE. On exit, if AUTOINC=1, every channel address += NCH, modulo 2^AWL.
- START alone in IDLE: o_START pulses next cycle. START with COMMIT in same write: latched pending, o_START pulses in the cycle after WRITE. START while pending already: no extra pulse.
- o_BUSY = (state != IDLE) or pending start.
- o_RDATA updates every enabled cycle from current i_ADDR, including while busy.
- i_EN=0: state, registers, pending flag held; o_RAM_Wr and o_START forced 0; they resume when i_EN returns.
- Reset (RST=0, any time, including mid-WAIT/WRITE): state IDLE, all data/address registers 0, AUTOINC 0, pending 0, all outputs 0. An interrupted commit is discarded.

## Timing
- Register write: visible on o_RAM_DATA/o_RAM_ADDR the cycle after the accepting edge.
- COMMIT with block low: o_RAM_Wr high exactly in cycle 1 after the accepting edge; data/addr stable throughout that cycle.
- Block high: o_RAM_Wr high in the first cycle following the edge at which i_RAM_BLOCK is sampled low.
- Auto-incremented addresses appear the cycle after o_RAM_Wr.
- o_START: cycle 1 after accept (alone) or cycle 1 after o_RAM_Wr (combined).
- Readback latency: 1 cycle.

## Test plan
- Reset values: drive RST=0 mid-WAIT -> all outputs 0, o_BUSY=0, subsequent COMMIT works normally.
- Defaults (NCH=2, WPS=2, CTRL at 6): write idx0=0x1234, idx1=0x5678, idx2=0x0005, COMMIT -> o_RAM_Wr one cycle with ch0 data 0x12345678, ch0 addr 5.
- Hold i_RAM_BLOCK=1 for 4 cycles after COMMIT -> o_BUSY high, idx0 write ignored, o_RAM_Wr one cycle after block drops.
- AUTOINC=1, ch0 addr 126, ch1 addr 127, COMMIT -> after write ch0 addr 0, ch1 addr 1 (wrap).
- CTRL=0b101 in one write -> o_RAM_Wr then o_START in the next cycle; single pulses only.
- i_EN low during WRITE -> no pulse while low; pulse appears once i_EN=1; idx 7 readback = 0.

Source files
------------

// File: rtl/fft_host_loader_if.sv
// Host register bus between the test/host side and fft_host_loader.
// The host drives the write strobe, index and data; the loader returns registered readback.
interface fft_host_loader_if #(
  parameter int BW = 16
);
  logic          i_WE;
  logic [7:0]    i_ADDR;
  logic [BW-1:0] i_DATA;
  logic [BW-1:0] o_RDATA;

  modport master (output i_WE, i_ADDR, i_DATA, input o_RDATA);
  modport slave  (input i_WE, i_ADDR, i_DATA, output o_RDATA);
endinterface

// File: rtl/fft_host_loader.sv
// Assembles NCH channel samples from narrow host bus words and commits them to the
// FFT core sample RAM, respecting the core's RAM block signal; can also launch the FFT.
module fft_host_loader #(
  parameter int IWL = 32,
  parameter int BW  = 16,
  parameter int AWL = 7,
  parameter int NCH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 i_EN,
  fft_host_loader_if.slave     host,
  input  logic                 i_RAM_BLOCK,
  output logic [NCH*IWL-1:0]   o_RAM_DATA,
  output logic [NCH*AWL-1:0]   o_RAM_ADDR,
  output logic                 o_RAM_Wr,
  output logic                 o_START,
  output logic                 o_BUSY
);

  localparam int WPS      = IWL / BW;
  localparam int S        = WPS + 1;
  localparam int CTRL_IDX = NCH * S;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_WRITE} state_e;

  state_e state_q, state_d;

  logic [BW-1:0]  data_q [NCH][WPS];
  logic [BW-1:0]  data_d [NCH][WPS];
  logic [AWL-1:0] addr_q [NCH];
  logic [AWL-1:0] addr_d [NCH];
  logic           autoinc_q, autoinc_d;
  logic           pend_q, pend_d;
  logic           start_q, start_d;
  logic [BW-1:0]  rdata_q, rdata_d;
  logic [BW-1:0]  rd_mux;

  logic acc, acc_ctrl, commit_req;

  // Host writes land only while idle; a commit in flight locks the register file.
  assign acc        = i_EN & host.i_WE & (state_q == ST_IDLE);
  assign acc_ctrl   = acc & (int'(host.i_ADDR) == CTRL_IDX);
  assign commit_req = acc_ctrl & host.i_DATA[0];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_EN) begin
      case (state_q)
        ST_IDLE:  if (commit_req) state_d = i_RAM_BLOCK ? ST_WAIT : ST_WRITE;
        ST_WAIT:  if (!i_RAM_BLOCK) state_d = ST_WRITE;
        ST_WRITE: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_RAM_Wr   = i_EN & (state_q == ST_WRITE);
    o_START    = i_EN & start_q;
    o_BUSY     = (state_q != ST_IDLE) | pend_q;
    o_RAM_DATA = '0;
    o_RAM_ADDR = '0;
    // Word 0 is the most significant slice of each channel's sample.
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < WPS; k++) begin
        o_RAM_DATA[c*IWL + (WPS-1-k)*BW +: BW] = data_q[c][k];
      end
      o_RAM_ADDR[c*AWL +: AWL] = addr_q[c];
    end
  end

  assign host.o_RDATA = rdata_q;

  always_comb begin
    data_d    = data_q;
    addr_d    = addr_q;
    autoinc_d = autoinc_q;
    pend_d    = pend_q;
    start_d   = start_q;
    rdata_d   = rdata_q;

    rd_mux = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < WPS; k++) begin
        if (int'(host.i_ADDR) == c*S + k) rd_mux = data_q[c][k];
      end
      if (int'(host.i_ADDR) == c*S + WPS) rd_mux = BW'(addr_q[c]);
    end
    if (int'(host.i_ADDR) == CTRL_IDX) rd_mux = BW'({autoinc_q, 1'b0});

    if (i_EN) begin
      start_d = 1'b0;
      rdata_d = rd_mux;
      if (acc) begin
        for (int c = 0; c < NCH; c++) begin
          for (int k = 0; k < WPS; k++) begin
            if (int'(host.i_ADDR) == c*S + k) data_d[c][k] = host.i_DATA;
          end
          if (int'(host.i_ADDR) == c*S + WPS) addr_d[c] = host.i_DATA[AWL-1:0];
        end
        if (acc_ctrl) begin
          autoinc_d = host.i_DATA[1];
          // START combined with COMMIT waits for the RAM write to finish.
          if (host.i_DATA[2]) begin
            if (host.i_DATA[0]) pend_d  = 1'b1;
            else                start_d = 1'b1;
          end
        end
      end
      if (state_q == ST_WRITE) begin
        if (autoinc_q) begin
          for (int c = 0; c < NCH; c++) addr_d[c] = addr_q[c] + AWL'(NCH);
        end
        start_d = start_d | pend_q;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < WPS; k++) data_q[c][k] <= '0;
        addr_q[c] <= '0;
      end
      autoinc_q <= 1'b0;
      pend_q    <= 1'b0;
      start_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_q    <= data_d;
      addr_q    <= addr_d;
      autoinc_q <= autoinc_d;
      pend_q    <= pend_d;
      start_q   <= start_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule
